// File: rtl/display_bcd_driver_pkg.sv
// Shared types and constants for the BCD display driver: FSM states and segment patterns.
// Latency: none (declarations only).
// Backpressure: not applicable.
package display_bcd_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Segment bit order: bit0 = a ... bit6 = g, active high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Indexed by 4-bit code: 0-9 standard digits, A-E blank, F dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH,                                          // F
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, // E..A
    7'h6F,                                             // 9
    7'h7F,                                             // 8
    7'h07,                                             // 7
    7'h7D,                                             // 6
    7'h6D,                                             // 5
    7'h66,                                             // 4
    7'h4F,                                             // 3
    7'h5B,                                             // 2
    7'h06,                                             // 1
    7'h3F                                              // 0
  };

endpackage

// File: rtl/display_bcd_driver_seg7_decode.sv
// Combinational 4-bit code to 7-segment pattern lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
module seg7_decode
  import display_bcd_driver_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[code];

endmodule

// File: rtl/display_bcd_driver.sv
// Converts a binary value to registered BCD digits and 7-segment patterns via serial double-dabble.
// Latency: load at edge N -> done high after edge N+IN_WIDTH+1; outputs update with done.
// Backpressure: busy is high during a conversion; loads while busy are dropped, not queued.
module display_bcd_driver
  import display_bcd_driver_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int IN_WIDTH  = 32,
  parameter int SIGNED_EN = 0,
  parameter int BLANK_LZ  = 0
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [IN_WIDTH-1:0]   valorsaida,
  input  logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  // One spare nibble above the displayed digits catches values that do not fit.
  localparam int SW = 4*DIGITS + 4;

  state_t                state, state_nxt;
  logic [SW-1:0]         scratch, scratch_adj, scratch_nxt;
  logic [IN_WIDTH-1:0]   mag, in_mag;
  logic                  neg, in_neg, ovf_acc, carry_out, ovf_fin, lz_run;
  logic [5:0]            cnt;
  logic [4*DIGITS-1:0]   code;
  logic [7*DIGITS-1:0]   seg_dec, seg_fin;

  // Magnitude is IN_WIDTH bits unsigned so the most negative input still fits.
  assign in_neg = (SIGNED_EN != 0) && valorsaida[IN_WIDTH-1];
  assign in_mag = in_neg ? (~valorsaida + IN_WIDTH'(1)) : valorsaida;
  assign busy   = (state == SHIFT) || (state == UPDATE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; clear forces IDLE and wins over load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == 6'(IN_WIDTH-1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // One double-dabble step: +3 on every nibble >= 5, then shift in the next magnitude bit.
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k <= DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    carry_out   = scratch_adj[SW-1];
    scratch_nxt = {scratch_adj[SW-2:0], mag[IN_WIDTH-1]};
  end

  // A negative value loses the top digit to the minus sign, so that digit must be zero.
  assign ovf_fin = ovf_acc | (neg & (scratch[4*(DIGITS-1) +: 4] != 4'd0));

  // Per-digit display code: dashes on overflow, minus in the top digit when negative.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      code[4*i +: 4] = ovf_fin ? 4'hF : scratch[4*i +: 4];
    end
    if (neg && !ovf_fin) code[4*DIGITS-1 -: 4] = 4'hF;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .code (code[4*g +: 4]),
      .seg  (seg_dec[7*g +: 7])
    );
  end

  // Leading-zero blanking walks down from the top digit; digit 0 and the minus sign are kept.
  always_comb begin
    seg_fin = seg_dec;
    lz_run  = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      lz_run = lz_run & (scratch[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && !ovf_fin && lz_run && !(neg && (i == DIGITS-1)))
        seg_fin[7*i +: 7] = SEG_BLANK;
    end
  end

  // Datapath: capture on load, shift during SHIFT, register display outputs in UPDATE.
  always_ff @(posedge clock) begin
    if (reset) begin
      scratch  <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      bcd      <= '0;
      seg      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        bcd      <= '0;
        seg      <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              mag     <= in_mag;
              neg     <= in_neg;
              scratch <= '0;
              ovf_acc <= 1'b0;
              cnt     <= '0;
            end
          end
          SHIFT: begin
            scratch <= scratch_nxt;
            mag     <= mag << 1;
            // Sticky: a 1 shifted out or anything in the spare nibble means no fit.
            ovf_acc <= ovf_acc | carry_out | (scratch_nxt[SW-1 -: 4] != 4'd0);
            cnt     <= cnt + 6'd1;
          end
          UPDATE: begin
            bcd      <= code;
            seg      <= seg_fin;
            overflow <= ovf_fin;
            done     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_bcd_driver.sv
// Bench for display_bcd_driver: default, signed and blanking instances driven in parallel.
// Latency: expects done exactly 33 edges after the load edge (IN_WIDTH=32).
// Backpressure: exercises loads while busy, mid-conversion reset and clear.
module tb_display_bcd_driver;

  logic        clock = 1'b0;
  logic        reset, load, clear;
  logic [31:0] valorsaida;
  logic        busy_w [3];
  logic        done_w [3];
  logic        ovf_w  [3];
  logic [15:0] bcd_w  [3];
  logic [27:0] seg_w  [3];
  int          checks   = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  display_bcd_driver u_def (
    .clock(clock), .reset(reset), .load(load), .valorsaida(valorsaida), .clear(clear),
    .busy(busy_w[0]), .done(done_w[0]), .overflow(ovf_w[0]), .bcd(bcd_w[0]), .seg(seg_w[0]));

  display_bcd_driver #(.SIGNED_EN(1)) u_sgn (
    .clock(clock), .reset(reset), .load(load), .valorsaida(valorsaida), .clear(clear),
    .busy(busy_w[1]), .done(done_w[1]), .overflow(ovf_w[1]), .bcd(bcd_w[1]), .seg(seg_w[1]));

  display_bcd_driver #(.BLANK_LZ(1)) u_blz (
    .clock(clock), .reset(reset), .load(load), .valorsaida(valorsaida), .clear(clear),
    .busy(busy_w[2]), .done(done_w[2]), .overflow(ovf_w[2]), .bcd(bcd_w[2]), .seg(seg_w[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference: decimal arithmetic on the value; idx 1 is signed, idx 2 blanks leading zeros.
  function automatic void model(input logic [31:0] v, input int idx,
                                output logic [15:0] eb, output logic [27:0] es, output logic eo);
    bit     sgn, blz, neg;
    longint mag;
    int     d;
    sgn = (idx == 1);
    blz = (idx == 2);
    neg = sgn && v[31];
    mag = longint'({32'd0, v});
    if (neg) mag = 64'd4294967296 - mag;
    eo = neg ? (mag > 999) : (mag > 9999);
    eb = '0;
    es = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'((mag / longint'(10**i)) % 10);
      if (eo || (neg && i == 3)) begin
        eb[4*i +: 4] = 4'hF;
        es[7*i +: 7] = 7'h40;
      end else begin
        eb[4*i +: 4] = 4'(d);
        es[7*i +: 7] = (blz && i > 0 && mag < longint'(10**i)) ? 7'h00 : seg_of(d);
      end
    end
  endfunction

  // kind: 0 plain, 1 second load at 'at', 2 reset at 'at', 3 clear at 'at', 4 clear with load.
  task automatic run(input logic [31:0] v, input int kind, input int at, input logic [31:0] v2);
    int          first  [3];
    int          npulse [3];
    logic [15:0] eb;
    logic [27:0] es;
    logic        eo;
    for (int i = 0; i < 3; i++) begin
      first[i]  = -1;
      npulse[i] = 0;
    end
    @(negedge clock);
    valorsaida = v;
    load       = 1'b1;
    if (kind == 4) clear = 1'b1;
    @(posedge clock); #1;
    load  = 1'b0;
    clear = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      if (kind == 1 && k == at) begin load = 1'b1; valorsaida = v2; end
      if (kind == 2 && k == at) reset = 1'b1;
      if (kind == 3 && k == at) clear = 1'b1;
      @(posedge clock); #1;
      load  = 1'b0;
      reset = 1'b0;
      clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          npulse[i]++;
          if (first[i] < 0) first[i] = k;
        end
        if (kind <= 1 && k == 10) check($sformatf("busy_mid%0d", i), 64'(busy_w[i]), 64'd1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_end%0d v=%0h", i, v), 64'(busy_w[i]), 64'd0);
      if (kind <= 1) begin
        model(v, i, eb, es, eo);
        check($sformatf("latency%0d v=%0h", i, v), 64'(first[i]), 64'd33);
        check($sformatf("pulses%0d v=%0h", i, v), 64'(npulse[i]), 64'd1);
        check($sformatf("bcd%0d v=%0h", i, v), 64'(bcd_w[i]), 64'(eb));
        check($sformatf("seg%0d v=%0h", i, v), 64'(seg_w[i]), 64'(es));
        check($sformatf("ovf%0d v=%0h", i, v), 64'(ovf_w[i]), 64'(eo));
      end else begin
        check($sformatf("nodone%0d k=%0d", i, kind), 64'(npulse[i]), 64'd0);
        check($sformatf("bcd0_%0d k=%0d", i, kind), 64'(bcd_w[i]), 64'd0);
        check($sformatf("seg0_%0d k=%0d", i, kind), 64'(seg_w[i]), 64'd0);
        check($sformatf("ovf0_%0d k=%0d", i, kind), 64'(ovf_w[i]), 64'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] rv;
    reset      = 1'b1;
    load       = 1'b0;
    clear      = 1'b0;
    valorsaida = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), 64'(busy_w[i]), 64'd0);
      check($sformatf("rst_done%0d", i), 64'(done_w[i]), 64'd0);
      check($sformatf("rst_ovf%0d", i),  64'(ovf_w[i]),  64'd0);
      check($sformatf("rst_bcd%0d", i),  64'(bcd_w[i]),  64'd0);
      check($sformatf("rst_seg%0d", i),  64'(seg_w[i]),  64'd0);
    end
    reset = 1'b0;

    run(32'd1234, 0, 0, 0);
    run(32'd10000, 0, 0, 0);
    run(32'hFFFF_FFD6, 0, 0, 0);   // -42
    run(32'hFFFF_FC18, 0, 0, 0);   // -1000
    run(32'hFFFF_FC19, 0, 0, 0);   // -999
    run(32'd7, 0, 0, 0);
    run(32'd0, 0, 0, 0);
    run(32'd9999, 0, 0, 0);
    run(32'd1005, 0, 0, 0);
    run(32'h8000_0000, 0, 0, 0);
    run(32'hFFFF_FFFF, 0, 0, 0);
    run(32'd4321, 1, 5, 32'd9876);
    run(32'd5678, 2, 10, 0);
    run(32'd1234, 0, 0, 0);
    run(32'd8765, 4, 0, 0);
    run(32'd2468, 0, 0, 0);
    run(32'd3333, 3, 20, 0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 9999);
        2:       rv = 32'd0 - $urandom_range(0, 1200);
        default: rv = $urandom_range(0, 120000);
      endcase
      run(rv, 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
